mem_io_responder: RTL and testbench

Memory-side responder for the RV32I core's byte-wide memory bus. It serves CPU reads and writes to a 128 KB on-chip RAM and a memory-mapped I/O window at `mem_a[17:16]==2'b11`. The I/O window contains a UART byte port, a cycle counter and a program-stop register. It drives the core's `rdy_in` for flow control, so it is the other end of the `mem_din`/`mem_dout`/`mem_a`/`mem_wr` interface.

---
 rtl/mem_io_responder_pkg.sv | 35 +++
 rtl/mem_io_responder_sync_fifo.sv | 64 ++++++
 rtl/mem_io_responder.sv | 153 +++++++++++++++
 tb/tb_mem_io_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants, types and decode helpers for the memory/IO responder.
package mem_io_responder_pkg;

  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned CPU_ADDR_WIDTH = 32;
  localparam int unsigned DECODE_WIDTH   = 18;

  localparam logic [1:0] IO_BASE = 2'b11;
  localparam logic [2:0] IO_UART = 3'h0;
  localparam logic [2:0] IO_CLK  = 3'h4;

  typedef enum logic [1:0] {
    IoNone,
    IoUart,
    IoClk
  } io_target_e;

  typedef enum logic {
    SrcIo,
    SrcRam
  } rd_src_e;

  // Only the first eight bytes of the IO window are populated.
  function automatic io_target_e io_decode(input logic [DECODE_WIDTH-1:0] a);
    if (a[17:16] != IO_BASE || a[15:3] != '0) return IoNone;
    if (a[2:0] == IO_UART) return IoUart;
    if (a[2] == IO_CLK[2]) return IoClk;
    return IoNone;
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    return w[8*sel +: 8];
  endfunction

endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count; head data reads as zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = count_q == CntW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU-side byte bus responder: on-chip RAM plus UART, cycle counter and halt IO window.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_mem_a,
  input  logic                      cpu_mem_wr,
  input  logic [DATA_WIDTH-1:0]     cpu_mem_dout,
  output logic [DATA_WIDTH-1:0]     cpu_mem_din,
  output logic                      rdy_out,
  input  logic                      rx_valid,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      rx_ready,
  output logic                      tx_valid,
  output logic [DATA_WIDTH-1:0]     tx_data,
  input  logic                      tx_ready,
  output logic                      halt
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  // Decode
  io_target_e             io_tgt;
  logic                   io_sel, rd_en, wr_en, clk_base;
  logic [ADDR_WIDTH-1:0]  ram_addr;
  logic                   unused_addr;

  assign io_sel      = cpu_mem_a[17:16] == IO_BASE;
  assign io_tgt      = io_decode(cpu_mem_a[DECODE_WIDTH-1:0]);
  assign clk_base    = (io_tgt == IoClk) && (cpu_mem_a[2:0] == IO_CLK);
  assign rd_en       = rdy_out && !cpu_mem_wr;
  assign wr_en       = rdy_out && cpu_mem_wr;
  assign ram_addr    = cpu_mem_a[ADDR_WIDTH-1:0];
  assign unused_addr = ^cpu_mem_a[CPU_ADDR_WIDTH-1:DECODE_WIDTH];

  // UART FIFOs
  logic                  tx_push, tx_empty, tx_full_unused;
  logic [DATA_WIDTH-1:0] tx_wdata;
  logic [CntW-1:0]       tx_count;
  logic                  rx_pop, rx_full;
  logic [DATA_WIDTH-1:0] rx_rdata;
  logic [CntW-1:0]       rx_count_unused;
  logic                  rx_empty_unused;

  // The halt write always emits a 0x00 marker, bypassing the zero filter.
  assign tx_push  = wr_en && ((io_tgt == IoUart && cpu_mem_dout != '0) || clk_base);
  assign tx_wdata = clk_base ? '0 : cpu_mem_dout;
  assign rx_pop   = rd_en && (io_tgt == IoUart);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (tx_push),
    .wdata_i (tx_wdata),
    .pop_i   (tx_ready),
    .rdata_o (tx_data),
    .count_o (tx_count),
    .full_o  (tx_full_unused),
    .empty_o (tx_empty)
  );

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (rx_valid),
    .wdata_i (rx_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_rdata),
    .count_o (rx_count_unused),
    .full_o  (rx_full),
    .empty_o (rx_empty_unused)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  // RAM
  logic [DATA_WIDTH-1:0] ram_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] ram_rdata_q;
  logic                  ram_we, ram_re;

  assign ram_we = wr_en && !io_sel;
  assign ram_re = rd_en && !io_sel;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_addr] <= cpu_mem_dout;
    if (ram_re) ram_rdata_q <= ram_q[ram_addr];
  end

  // Counter, snapshot, halt and IO read data
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           snap_q, snap_d;
  logic                  halt_q, halt_d;
  rd_src_e               rd_src_q, rd_src_d;
  logic [DATA_WIDTH-1:0] io_rdata_q, io_rdata_d;
  logic [DATA_WIDTH-1:0] io_rdata;

  // Byte 0 reads the live counter; bytes 1..3 come from the snapshot it took.
  always_comb begin
    io_rdata = '0;
    unique case (io_tgt)
      IoUart:  io_rdata = rx_rdata;
      IoClk:   io_rdata = clk_base ? cnt_q[7:0] : word_byte(snap_q, cpu_mem_a[1:0]);
      default: io_rdata = '0;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q + 32'd1;
    snap_d     = snap_q;
    halt_d     = halt_q;
    rd_src_d   = rd_src_q;
    io_rdata_d = io_rdata_q;
    if (rd_en) begin
      rd_src_d = io_sel ? SrcIo : SrcRam;
      if (io_sel)   io_rdata_d = io_rdata;
      if (clk_base) snap_d = cnt_q;
    end
    if (wr_en && clk_base) halt_d = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q      <= '0;
      snap_q     <= '0;
      halt_q     <= 1'b0;
      rd_src_q   <= SrcIo;
      io_rdata_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      halt_q     <= halt_d;
      rd_src_q   <= rd_src_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  // One slot is always kept free so a write in the current cycle cannot overflow.
  assign rdy_out     = !halt_q && (tx_count < CntW'(FIFO_DEPTH - 1));
  assign halt        = halt_q;
  assign cpu_mem_din = (rd_src_q == SrcRam) ? ram_rdata_q : io_rdata_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench: random and directed CPU/UART traffic against a queue-based reference model.
module tb_mem_io_responder;

  localparam int unsigned D = 8;
  localparam logic [31:0] IdleAddr = 32'h0003_000C;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] cpu_mem_a = IdleAddr;
  logic        cpu_mem_wr = 1'b0;
  logic [7:0]  cpu_mem_dout = 8'h00;
  logic [7:0]  cpu_mem_din;
  logic        rdy_out;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        halt;

  mem_io_responder #(
    .ADDR_WIDTH (17),
    .FIFO_DEPTH (D)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .cpu_mem_a    (cpu_mem_a),
    .cpu_mem_wr   (cpu_mem_wr),
    .cpu_mem_dout (cpu_mem_dout),
    .cpu_mem_din  (cpu_mem_din),
    .rdy_out      (rdy_out),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .halt         (halt)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state (as of after the most recent clock edge)
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [7:0]  rd_expq[$];
  logic [7:0]  ram_m[int];
  logic [7:0]  din_m   = 8'h00;
  bit          rd_pend = 1'b0;
  bit          halt_m  = 1'b0;
  logic [31:0] cnt_m   = 32'h0;
  logic [31:0] snap_m  = 32'h0;

  task automatic reset_model();
    rxq.delete();
    txq.delete();
    rd_expq.delete();
    din_m   = 8'h00;
    rd_pend = 1'b0;
    halt_m  = 1'b0;
    cnt_m   = 32'h0;
    snap_m  = 32'h0;
  endtask

  task automatic model_cycle();
    logic        en, tx_pop, rx_push, rx_pop, io;
    logic [15:0] off;
    logic [7:0]  exp;
    logic [31:0] sh;
    // Compare the DUT against the model's post-edge state.
    check("rdy_out", rdy_out, !halt_m && (txq.size() < D - 1));
    check("rx_ready", rx_ready, rxq.size() < D);
    check("halt", halt, halt_m);
    check("tx_valid", tx_valid, txq.size() != 0);
    if (txq.size() != 0) check("tx_data", tx_data, txq[0]);
    if (rd_pend) begin
      din_m   = rd_expq.pop_front();
      rd_pend = 1'b0;
    end
    check("cpu_mem_din", cpu_mem_din, din_m);

    // Advance the model across the coming edge.
    en      = !halt_m && (txq.size() < D - 1);
    tx_pop  = (txq.size() != 0) && tx_ready;
    rx_push = rx_valid && (rxq.size() < D);
    rx_pop  = 1'b0;
    io      = cpu_mem_a[17:16] == 2'b11;
    off     = cpu_mem_a[15:0];
    if (en && !cpu_mem_wr) begin
      exp = 8'h00;
      if (!io) begin
        exp = ram_m[int'(cpu_mem_a[16:0])];
      end else if (off == 16'h0) begin
        if (rxq.size() != 0) begin
          exp    = rxq[0];
          rx_pop = 1'b1;
        end
      end else if (off == 16'h4) begin
        exp    = cnt_m[7:0];
        snap_m = cnt_m;
      end else if (off inside {[16'h5:16'h7]}) begin
        sh  = snap_m >> (8 * off[1:0]);
        exp = sh[7:0];
      end
      rd_expq.push_back(exp);
      rd_pend = 1'b1;
    end
    if (tx_pop) void'(txq.pop_front());
    if (en && cpu_mem_wr) begin
      if (!io) ram_m[int'(cpu_mem_a[16:0])] = cpu_mem_dout;
      else if (off == 16'h0 && cpu_mem_dout != 8'h00) txq.push_back(cpu_mem_dout);
      else if (off == 16'h4) begin
        halt_m = 1'b1;
        txq.push_back(8'h00);
      end
    end
    if (rx_pop) void'(rxq.pop_front());
    if (rx_push) rxq.push_back(rx_data);
    cnt_m = cnt_m + 32'd1;
  endtask

  // Monitor: runs 2 time units after each falling edge, once stimulus has settled.
  initial begin
    forever begin
      @(negedge clk_in);
      #2;
      if (rst_in) reset_model();
      else model_cycle();
    end
  end

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_mem_a    = a;
    cpu_mem_wr   = wr;
    cpu_mem_dout = d;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      drive(IdleAddr, 1'b0, 8'h00);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic wr, input logic [7:0] d);
    int w = 0;
    @(negedge clk_in);
    drive(IdleAddr, 1'b0, 8'h00);
    while (!rdy_out && w < 100) begin
      @(negedge clk_in);
      w++;
    end
    check("rdy_wait", rdy_out, 1'b1);
    drive(a, wr, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"}, cpu_mem_din, 8'h00);
    check({tag, "_rdy"}, rdy_out, 1'b1);
    check({tag, "_tx_valid"}, tx_valid, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_rx_ready"}, rx_ready, 1'b1);
    check({tag, "_halt"}, halt, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic [31:0] other_io [8];
    int          sel, idx, w;
    other_io = '{32'h30001, 32'h30002, 32'h30003, 32'h30008,
                 32'h3000F, 32'h30010, 32'h3FFFF, 32'h30006};

    // Reset
    idle_cycles(3);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check_reset_outputs("reset");

    // RAM round-trip
    access(32'h0000_0123, 1'b1, 8'hA5);
    access(32'h0000_0123, 1'b0, 8'h00);
    idle_cycles(2);

    // UART TX: zero byte is filtered
    tx_ready = 1'b1;
    access(32'h0003_0000, 1'b1, 8'h41);
    access(32'h0003_0000, 1'b1, 8'h00);
    idle_cycles(4);

    // Backpressure
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) access(32'h0003_0000, 1'b1, 8'h55);
    idle_cycles(3);
    tx_ready = 1'b1;
    idle_cycles(10);

    // RX
    @(negedge clk_in);
    drive(IdleAddr, 1'b0, 8'h00);
    rx_valid = 1'b1;
    rx_data  = 8'h31;
    @(negedge clk_in);
    rx_data = 8'h32;
    @(negedge clk_in);
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) access(32'h0003_0000, 1'b0, 8'h00);
    idle_cycles(2);

    // Counter coherence: read byte 0 at 0xFF, then byte 1 from the snapshot
    w = 0;
    @(negedge clk_in);
    drive(IdleAddr, 1'b0, 8'h00);
    while (cnt_m != 32'hFF && w < 400) begin
      @(negedge clk_in);
      w++;
    end
    check("cnt_reach", cnt_m, 32'hFF);
    drive(32'h0003_0004, 1'b0, 8'h00);
    @(negedge clk_in);
    drive(32'h0003_0005, 1'b0, 8'h00);
    idle_cycles(2);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_in);
      tx_ready = ($urandom_range(0, 1) == 1);
      rx_valid = ($urandom_range(0, 9) < 3);
      rx_data  = 8'($urandom);
      sel      = $urandom_range(0, 9);
      if (sel <= 3) begin
        idx  = $urandom_range(0, 15);
        addr = (idx < 8) ? 32'h100 + 32'(idx) : 32'h1FFF0 + 32'(idx);
        if ($urandom_range(0, 1) == 1 || !ram_m.exists(int'(addr[16:0])))
          drive(addr, 1'b1, 8'($urandom));
        else
          drive(addr, 1'b0, 8'h00);
      end else if (sel <= 5) begin
        drive(32'h0003_0000, 1'b1, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      end else if (sel == 6) begin
        drive(32'h0003_0000, 1'b0, 8'h00);
      end else if (sel == 7) begin
        drive(32'h0003_0004 + 32'($urandom_range(0, 3)), 1'b0, 8'h00);
      end else if (sel == 8) begin
        drive(other_io[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), 8'($urandom));
      end else begin
        drive(IdleAddr, 1'b0, 8'h00);
      end
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    idle_cycles(12);

    // Halt, then reset in the middle of draining
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) access(32'h0003_0000, 1'b1, 8'h55);
    access(32'h0003_0004, 1'b1, 8'h7E);
    idle_cycles(2);
    tx_ready = 1'b1;
    idle_cycles(2);
    @(negedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    idle_cycles(2);
    @(negedge clk_in);
    rst_in = 1'b0;
    access(32'h0000_0123, 1'b0, 8'h00);
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
